// File: rtl/mmio_host_arbiter_if.sv
// MMIO request/ack bundle: a host raises read_req or write_req and holds it until the matching ack.
// Modport host drives requests; modport device answers with acks and read data.
interface mmio_if #(
    parameter int IDX_W  = 16,
    parameter int DATA_W = 32
);
    logic              read_req;
    logic              write_req;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              read_ack;
    logic              write_ack;

    modport host (
        output read_req, write_req, index, write_data,
        input  read_data, read_ack, write_ack
    );

    modport device (
        input  read_req, write_req, index, write_data,
        output read_data, read_ack, write_ack
    );
endinterface

// File: rtl/mmio_host_arbiter.sv
// Two-host MMIO arbiter onto one pe port; req-to-ack = pe ack latency + 2, one transaction in flight, requests held by hosts until served.
// Optional ISSUE watchdog under `MMIO_ARBITER_TIMEOUT_EN` (aborts after TIMEOUT_CYCLES, returns 32'hDEAD_BEEF on reads).
module mmio_host_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int          IDX_W          = 16,
    parameter int          DATA_W         = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    mmio_if.device     host_0_interface,
    mmio_if.device     host_1_interface,
    mmio_if.host       pe_interface,
    output logic       busy,
    output logic       owner,
    output logic [7:0] timeout_count
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              owner_q, owner_d;
    logic              is_wr_q, is_wr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [7:0]        tocount_q, tocount_d;

    logic req0, req1, gnt, pe_ack, served_req;

    assign req0 = host_0_interface.read_req | host_0_interface.write_req;
    assign req1 = host_1_interface.read_req | host_1_interface.write_req;
    assign pe_ack = is_wr_q ? pe_interface.write_ack : pe_interface.read_ack;

`ifdef MMIO_ARBITER_TIMEOUT_EN
    logic [15:0] tcnt_q, tcnt_d;
    logic        tcnt_hit;

    assign tcnt_hit = (tcnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`endif

    // Served req of the current owner: release waits on this alone so a held req is not replayed
    always_comb begin
        served_req = 1'b0;
        if (owner_q) begin
            served_req = is_wr_q ? host_1_interface.write_req : host_1_interface.read_req;
        end else begin
            served_req = is_wr_q ? host_0_interface.write_req : host_0_interface.read_req;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        is_wr_d   = is_wr_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        tocount_d = tocount_q;
        gnt       = 1'b0;
`ifdef MMIO_ARBITER_TIMEOUT_EN
        tcnt_d    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt     = (req0 && req1) ? ptr_q : req1;
                    owner_d = gnt;
                    if (gnt) begin
                        is_wr_d = host_1_interface.write_req;
                        idx_d   = host_1_interface.index;
                        wdata_d = host_1_interface.write_data;
                    end else begin
                        is_wr_d = host_0_interface.write_req;
                        idx_d   = host_0_interface.index;
                        wdata_d = host_0_interface.write_data;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (pe_ack) begin
                    if (!is_wr_q) begin
                        rdata_d = pe_interface.read_data;
                    end
                    state_d = RESPOND;
                end
`ifdef MMIO_ARBITER_TIMEOUT_EN
                else if (tcnt_hit) begin
                    if (!is_wr_q) begin
                        rdata_d = DATA_W'(32'hDEAD_BEEF);
                    end
                    if (tocount_q != 8'hFF) begin
                        tocount_d = tocount_q + 8'd1;
                    end
                    state_d = RESPOND;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
`endif
            end
            RESPOND: begin
                ptr_d   = ~owner_q;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!served_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            is_wr_q   <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            tocount_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            is_wr_q   <= is_wr_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            tocount_q <= tocount_d;
        end
    end

    // Everything below decodes from registered state, so async reset clears it immediately
    always_comb begin
        logic issue, resp;
        issue = (state_q == ISSUE);
        resp  = (state_q == RESPOND);

        pe_interface.read_req   = issue && !is_wr_q;
        pe_interface.write_req  = issue && is_wr_q;
        pe_interface.index      = issue ? idx_q : '0;
        pe_interface.write_data = (issue && is_wr_q) ? wdata_q : '0;

        host_0_interface.write_ack = resp && !owner_q && is_wr_q;
        host_0_interface.read_ack  = resp && !owner_q && !is_wr_q;
        host_0_interface.read_data = (resp && !owner_q && !is_wr_q) ? rdata_q : '0;

        host_1_interface.write_ack = resp && owner_q && is_wr_q;
        host_1_interface.read_ack  = resp && owner_q && !is_wr_q;
        host_1_interface.read_data = (resp && owner_q && !is_wr_q) ? rdata_q : '0;
    end

    assign busy  = (state_q != IDLE);
    assign owner = owner_q;

`ifdef MMIO_ARBITER_TIMEOUT_EN
    assign timeout_count = tocount_q;
`else
    assign timeout_count = 8'd0;
`endif

endmodule

// File: tb/tb_mmio_host_arbiter.sv
// Directed bench for mmio_host_arbiter; timeout scenario selected by MMIO_ARBITER_TIMEOUT_EN.
module tb_mmio_host_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        busy;
    logic        owner;
    logic [7:0]  timeout_count;

    logic        pe_ack_en;
    logic [31:0] pe_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] wlog[$];
    logic        olog[$];
    logic [15:0] ilog[$];
    logic        oplog[$];

    mmio_if h0 ();
    mmio_if h1 ();
    mmio_if pe ();

    mmio_host_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .host_0_interface (h0),
        .host_1_interface (h1),
        .pe_interface     (pe),
        .busy             (busy),
        .owner            (owner),
        .timeout_count    (timeout_count)
    );

    always #5 clock = ~clock;

    // Downstream model: acks in the same cycle as the req when enabled
    assign pe.read_ack  = pe_ack_en & pe.read_req;
    assign pe.write_ack = pe_ack_en & pe.write_req;
    assign pe.read_data = pe_rdata;

    always @(posedge clock) begin
        if (reset_n && pe.write_req && pe.write_ack) begin
            wlog.push_back(pe.write_data);
            olog.push_back(owner);
            ilog.push_back(pe.index);
        end
        if (reset_n && ((pe.read_req && pe.read_ack) || (pe.write_req && pe.write_ack))) begin
            oplog.push_back(pe.write_req);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic hosts_idle();
        h0.read_req = 1'b0; h0.write_req = 1'b0; h0.index = '0; h0.write_data = '0;
        h1.read_req = 1'b0; h1.write_req = 1'b0; h1.index = '0; h1.write_data = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        hosts_idle();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int          n0;
        int          issue_cyc;
        logic        got;
        logic [31:0] rd;
        int          order[$];
        int          kinds[$];
        logic        any_ack;

        reset_n   = 1'b0;
        pe_ack_en = 1'b1;
        pe_rdata  = 32'h1234_5678;
        hosts_idle();
        #1;
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_tocnt", 32'(timeout_count), 32'd0);
        chk("rst_pe_req", 32'({pe.read_req, pe.write_req}), 32'd0);
        chk("rst_pe_idx", 32'(pe.index), 32'd0);
        chk("rst_h_ack", 32'({h0.read_ack, h0.write_ack, h1.read_ack, h1.write_ack}), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Single read from host 0: req in cycle 1, ISSUE in cycle 2, ack in cycle 3
        h0.read_req = 1'b1;
        h0.index    = 16'h0010;
        chk("t1_c1_ack", 32'(h0.read_ack), 32'd0);
        tick();
        chk("t1_c2_busy", 32'(busy), 32'd1);
        chk("t1_c2_pereq", 32'(pe.read_req), 32'd1);
        chk("t1_c2_peidx", 32'(pe.index), 32'h10);
        chk("t1_c2_ack", 32'(h0.read_ack), 32'd0);
        tick();
        chk("t1_c3_ack", 32'(h0.read_ack), 32'd1);
        chk("t1_c3_data", h0.read_data, 32'h1234_5678);
        chk("t1_c3_pereq", 32'(pe.read_req), 32'd0);
        chk("t1_c3_h1ack", 32'({h1.read_ack, h1.write_ack}), 32'd0);
        h0.read_req = 1'b0;
        tick();
        chk("t1_c4_ack", 32'(h0.read_ack), 32'd0);
        chk("t1_c4_data", h0.read_data, 32'd0);
        chk("t1_c4_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_c5_busy", 32'(busy), 32'd0);

        // Simultaneous writes right after reset: host 0 first, host 1 not lost
        do_reset();
        wlog.delete(); olog.delete(); ilog.delete();
        h0.write_req = 1'b1; h0.index = 16'h0001; h0.write_data = 32'hAAAA_0000;
        h1.write_req = 1'b1; h1.index = 16'h0002; h1.write_data = 32'hBBBB_0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (h0.write_ack) begin order.push_back(0); h0.write_req = 1'b0; end
            if (h1.write_ack) begin order.push_back(1); h1.write_req = 1'b0; end
        end
        chk("t2_nack", 32'(order.size()), 32'd2);
        chk("t2_first", 32'(order[0]), 32'd0);
        chk("t2_second", 32'(order[1]), 32'd1);
        chk("t2_nwr", 32'(wlog.size()), 32'd2);
        chk("t2_wd0", wlog[0], 32'hAAAA_0000);
        chk("t2_wd1", wlog[1], 32'hBBBB_0001);
        chk("t2_own0", 32'(olog[0]), 32'd0);
        chk("t2_own1", 32'(olog[1]), 32'd1);
        chk("t2_idx0", 32'(ilog[0]), 32'h1);
        chk("t2_idx1", 32'(ilog[1]), 32'h2);

        // Host 1 holds its write req after the ack: single pe write, arbiter parked in RELEASE
        n0 = wlog.size();
        got = 1'b0;
        h1.write_req = 1'b1; h1.index = 16'h0003; h1.write_data = 32'h0000_C0DE;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = h1.write_ack;
        end
        chk("t3_ack", 32'(got), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_hold_busy", 32'(busy), 32'd1);
            chk("t3_hold_ack", 32'(h1.write_ack), 32'd0);
        end
        h1.write_req = 1'b0;
        repeat (2) tick();
        chk("t3_idle", 32'(busy), 32'd0);
        chk("t3_nwr", 32'(wlog.size() - n0), 32'd1);
        chk("t3_wd", wlog[n0], 32'h0000_C0DE);

        // Host 0 raises read and write together: write first, then read, two acks
        n0 = oplog.size();
        pe_rdata = 32'h0BAD_F00D;
        h0.read_req = 1'b1; h0.write_req = 1'b1; h0.index = 16'h0005; h0.write_data = 32'h55;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (h0.write_ack) begin kinds.push_back(1); h0.write_req = 1'b0; end
            if (h0.read_ack) begin
                kinds.push_back(0);
                chk("t4_rdata", h0.read_data, 32'h0BAD_F00D);
                h0.read_req = 1'b0;
            end
        end
        chk("t4_nack", 32'(kinds.size()), 32'd2);
        chk("t4_ack0_wr", 32'(kinds[0]), 32'd1);
        chk("t4_ack1_rd", 32'(kinds[1]), 32'd0);
        chk("t4_nops", 32'(oplog.size() - n0), 32'd2);
        chk("t4_op0_wr", 32'(oplog[n0]), 32'd1);
        chk("t4_op1_rd", 32'(oplog[n0 + 1]), 32'd0);

        // pe never acks a read
        pe_ack_en = 1'b0;
        h0.read_req = 1'b1; h0.index = 16'h0007;
        issue_cyc = 0;
        got = 1'b0;
        rd  = '0;
`ifdef MMIO_ARBITER_TIMEOUT_EN
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (pe.read_req) issue_cyc++;
            if (h0.read_ack) begin got = 1'b1; rd = h0.read_data; h0.read_req = 1'b0; end
        end
        chk("t5_ack", 32'(got), 32'd1);
        chk("t5_issue_cyc", 32'(issue_cyc), 32'd8);
        chk("t5_data", rd, 32'hDEAD_BEEF);
        repeat (2) tick();
        chk("t5_tocnt", 32'(timeout_count), 32'd1);
        chk("t5_idle", 32'(busy), 32'd0);
        h0.read_req = 1'b1;
`else
        for (int i = 0; i < 30; i++) begin
            tick();
            if (pe.read_req) issue_cyc++;
            if (h0.read_ack) got = 1'b1;
        end
        chk("t5_noack", 32'(got), 32'd0);
        chk("t5_issue_cyc", 32'(issue_cyc), 32'd30);
        chk("t5_tocnt", 32'(timeout_count), 32'd0);
`endif

        // Reset pulsed during ISSUE: pe req drops at once, no ack, then re-arbitration
        tick();
        tick();
        chk("t6_in_issue", 32'(pe.read_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_pe_req", 32'({pe.read_req, pe.write_req}), 32'd0);
        chk("t6_pe_idx", 32'(pe.index), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_owner", 32'(owner), 32'd0);
        chk("t6_tocnt", 32'(timeout_count), 32'd0);
        any_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            any_ack |= h0.read_ack | h0.write_ack | h1.read_ack | h1.write_ack;
        end
        chk("t6_no_ack", 32'(any_ack), 32'd0);
        pe_ack_en = 1'b1;
        pe_rdata  = 32'hCAFE_0042;
        reset_n   = 1'b1;
        tick();
        chk("t6_regrant", 32'(pe.read_req), 32'd1);
        tick();
        chk("t6_ack", 32'(h0.read_ack), 32'd1);
        chk("t6_data", h0.read_data, 32'hCAFE_0042);
        h0.read_req = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_host_arbiter.md
MMIO_HOST_ARBITER -- requirements
Module: mmio_host_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: downstream cycles waited for an ack before abort (range 1..65535).
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port host_0_interface, mmio_if.device, bundle: requester 0 (config loader), the higher-priority requester after reset.
REQ-005 SHALL have port host_1_interface, mmio_if.device, bundle: requester 1 (test/debug host).
REQ-006 SHALL have port pe_interface, mmio_if.host, bundle: the shared downstream port into the processing-element core/router map.
REQ-007 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-008 SHALL have port owner, output, 1: index of the granted requester, valid while busy.
REQ-009 SHALL have port timeout_count, output, 8: saturating count of aborted transactions.

Function
REQ-010 SHALL serve exactly one transaction (read or write) at a time; the four states are IDLE, ISSUE, RESPOND and RELEASE.
REQ-011 In IDLE, SHALL grant the requester that has read_req or write_req high; if both requesters request, SHALL grant the one selected by the round-robin pointer.
REQ-012 Round-robin pointer SHALL point at the other requester after each RESPOND; reset value selects host 0.
REQ-013 If one requester asserts read_req and write_req together, SHALL serve the write first.
REQ-014 On grant, SHALL register owner, operation, index and write_data, then enter ISSUE the next cycle.
REQ-015 In ISSUE, SHALL drive the registered req, index and data onto pe_interface, holding them constant until the pe ack is sampled high.
REQ-016 When the pe ack is sampled high in ISSUE, SHALL capture read_data (reads) and enter RESPOND, deasserting the pe req in that same cycle.
REQ-017 In RESPOND (exactly one cycle), SHALL assert the matching ack to the owner, with read_data driven from the capture register; all other acks SHALL be 0.
REQ-018 RELEASE SHALL hold until the owner's served req is low, then enter IDLE; this prevents a held req being served twice.
REQ-019 A non-owner's req SHALL be ignored (ack 0, read_data 0) until that requester is granted; its request SHALL not be lost.
REQ-020 Best-case latency, from req sampled in IDLE to requester ack, SHALL be (pe ack latency + 2) cycles; with a combinational pe ack this is 3 cycles.
REQ-021 All pe_interface req, index and data outputs SHALL be 0 outside ISSUE.
REQ-022 Index and data widths SHALL equal the mmio_if widths; indices SHALL pass through unmodified.

Reset
REQ-023 reset_n low SHALL immediately set state IDLE, pointer 0, busy 0, owner 0 and timeout_count 0, and drive every req and ack to 0 and every index and data output to 0.
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction with no ack to any requester; after release, the arbiter SHALL re-arbitrate from IDLE.

Configuration
REQ-025 With MMIO_ARBITER_TIMEOUT_EN defined, SHALL count cycles in ISSUE. When the count reaches TIMEOUT_CYCLES without a pe ack, SHALL drop the pe req, enter RESPOND with read_data 32'hDEAD_BEEF (reads), and increment timeout_count, saturating at 255.
REQ-026 Without MMIO_ARBITER_TIMEOUT_EN, ISSUE SHALL wait indefinitely, no counter SHALL be built, and timeout_count SHALL be tied to 0.

Verification
REQ-027 Host 0 reads index 0x10, pe acks combinationally with 0x1234_5678 -> host 0 read_ack one cycle, 3 cycles after req, with data 0x1234_5678.
REQ-028 Both hosts write in the same cycle after reset -> host 0 served first, host 1 next; pe write_data order matches; owner sequence is 0 then 1.
REQ-029 Host 1 holds write_req 4 cycles after its ack -> exactly one pe write issued; arbiter stays in RELEASE until req drops.
REQ-030 Host 0 asserts read_req and write_req together -> write issued before read; two separate acks.
REQ-031 TIMEOUT_EN defined, TIMEOUT_CYCLES=8, pe never acks a read -> ack after 8 ISSUE cycles, data 0xDEAD_BEEF, timeout_count 1.
REQ-032 reset_n pulsed low during ISSUE -> pe req drops asynchronously, no host ack is produced, and busy is 0.
